fifo_narrow_to_wide: RTL and testbench

FIFO_NARROW_TO_WIDE -- requirements
Module: fifo_narrow_to_wide

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_ctrl_n2w.sv | 68 ++++++
 rtl/fifo_narrow_to_wide.sv | 47 ++++
 tb/tb_fifo_narrow_to_wide.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults for the narrow-to-wide FIFO and the helper that
// gives the read-side word width.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 3;

    function automatic int wide_width(input int data_width);
        return 2 * data_width;
    endfunction

endpackage

// File: rtl/fifo_ctrl_n2w.sv
// Pointer, occupancy and flag control for the narrow-to-wide FIFO.
// The write side advances one narrow entry; the read side advances a pair.
module fifo_ctrl_n2w
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  wr_ok,
    output logic [ADDR_WIDTH-1:0] w_ptr,
    output logic [ADDR_WIDTH-2:0] r_ptr,
    output logic                  full,
    output logic                  empty
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH = CW'(1) << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH-2:0] r_ptr_q, r_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  rd_ok;

    // Requests are judged against the registered flags, so wr and rd in
    // the same cycle are accepted independently.
    always_comb begin
        wr_ok   = wr & ~full_q;
        rd_ok   = rd & ~empty_q;
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        if (wr_ok) begin
            w_ptr_d = w_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            r_ptr_d = r_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(wr_ok) - CW'({rd_ok, 1'b0});
        full_d  = (count_d == DEPTH);
        empty_d = (count_d < CW'(2));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign w_ptr = w_ptr_q;
    assign r_ptr = r_ptr_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/fifo_narrow_to_wide.sv
// FIFO written one narrow word at a time and read two words at a time,
// earliest word in the low half, with first-word fall-through.
module fifo_narrow_to_wide
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wr,
    input  logic [DATA_WIDTH-1:0]             w_data,
    input  logic                              rd,
    output logic [wide_width(DATA_WIDTH)-1:0] r_data,
    output logic                              full,
    output logic                              empty
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic                  wr_ok;
    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [ADDR_WIDTH-2:0] r_ptr;

    fifo_ctrl_n2w #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ctrl (
        .clk   (clk),
        .reset (reset),
        .wr    (wr),
        .rd    (rd),
        .wr_ok (wr_ok),
        .w_ptr (w_ptr),
        .r_ptr (r_ptr),
        .full  (full),
        .empty (empty)
    );

    // Storage is never cleared; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[w_ptr] <= w_data;
        end
    end

    assign r_data = {mem_q[{r_ptr, 1'b1}], mem_q[{r_ptr, 1'b0}]};

endmodule

// File: tb/tb_fifo_narrow_to_wide.sv
// Self-checking bench: directed scenarios plus random traffic compared
// against a queue-of-bytes reference model.
module tb_fifo_narrow_to_wide;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr;
    logic          rd;
    logic [DW-1:0] w_data;
    logic [2*DW-1:0] r_data;
    logic          full;
    logic          empty;

    int tests  = 0;
    int failed = 0;
    logic [7:0] model_q[$];

    always #5 clk = ~clk;

    fifo_narrow_to_wide #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .w_data (w_data),
        .rd     (rd),
        .r_data (r_data),
        .full   (full),
        .empty  (empty)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock with the given requests; the model decides acceptance from
    // its own occupancy before the edge, then all outputs are compared.
    task automatic step(input logic w, input logic r, input logic [7:0] d, input string tag);
        logic w_ok;
        logic r_ok;
        @(negedge clk);
        wr     = w;
        rd     = r;
        w_data = d;
        w_ok   = w && (model_q.size() < DEPTH);
        r_ok   = r && (model_q.size() >= 2);
        @(posedge clk);
        if (r_ok) begin
            void'(model_q.pop_front());
            void'(model_q.pop_front());
        end
        if (w_ok) model_q.push_back(d);
        #1;
        check({tag, ".full"}, 32'(full), 32'(model_q.size() == DEPTH));
        check({tag, ".empty"}, 32'(empty), 32'(model_q.size() < 2));
        if (model_q.size() >= 2) check({tag, ".rdata"}, 32'(r_data), 32'({model_q[1], model_q[0]}));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        #1;
        check({tag, ".rst_empty"}, 32'(empty), 32'd1);
        check({tag, ".rst_full"}, 32'(full), 32'd0);
        model_q.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset  = 1'b1;
        wr     = 1'b0;
        rd     = 1'b0;
        w_data = '0;

        // Basic pair assembly
        do_reset("r029");
        step(1'b1, 1'b0, 8'hEF, "r029.w0");
        check("r029.empty_after_1", 32'(empty), 32'd1);
        step(1'b1, 1'b0, 8'hBE, "r029.w1");
        check("r029.empty_after_2", 32'(empty), 32'd0);
        check("r029.rdata", 32'(r_data), 32'h0000BEEF);

        // Fill, overflow attempt, drain
        do_reset("r030");
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(i), "r030.fill");
        check("r030.full", 32'(full), 32'd1);
        step(1'b1, 1'b0, 8'hFF, "r030.ovf");
        check("r030.full_after_ovf", 32'(full), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check("r030.head", 32'(r_data), 32'({8'(2 * k + 2), 8'(2 * k + 1)}));
            step(1'b0, 1'b1, 8'h00, "r030.read");
        end
        check("r030.empty_end", 32'(empty), 32'd1);

        // Odd trailing word and read while empty
        do_reset("r031");
        step(1'b1, 1'b0, 8'hAA, "r031.wAA");
        step(1'b0, 1'b1, 8'h00, "r031.rd_empty");
        check("r031.still_empty", 32'(empty), 32'd1);
        step(1'b1, 1'b1, 8'hBB, "r031.wBB_rd");
        check("r031.rdata", 32'(r_data), 32'h0000BBAA);
        check("r031.empty", 32'(empty), 32'd0);

        // Simultaneous wr/rd while full
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h50 + i), "r032.fill");
        check("r032.full", 32'(full), 32'd1);
        step(1'b1, 1'b1, 8'h99, "r032.wr_rd");
        check("r032.full_after", 32'(full), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, "r032.drain");
        check("r032.empty_after_3", 32'(empty), 32'd1);

        // Wrap with alternating traffic
        do_reset("r033");
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 8'(8'h10 + 2 * i), "r033.wlo");
            step(1'b1, 1'b0, 8'(8'h11 + 2 * i), "r033.whi");
            check("r033.pair", 32'(r_data), 32'({8'(8'h11 + 2 * i), 8'(8'h10 + 2 * i)}));
            step(1'b0, 1'b1, 8'h00, "r033.rd");
        end

        // Asynchronous reset mid-stream with an odd word stored
        do_reset("r034.pre");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), "r034.fill");
        do_reset("r034.mid");
        step(1'b1, 1'b0, 8'h34, "r034.w34");
        check("r034.empty_1", 32'(empty), 32'd1);
        step(1'b1, 1'b0, 8'h12, "r034.w12");
        check("r034.rdata", 32'(r_data), 32'h00001234);

        // Random traffic against the model
        do_reset("rand");
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 40),
                 8'($urandom), "rand");
        end
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 60),
                 8'($urandom), "rand2");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
